// File: rtl/dmem_if.sv
// Core-side data-memory port: request (ce/we/addr/data) from the core and
// completion (ready/err/data) from the responder.
interface dmem_if #(
  parameter int WORD_BITWIDTH = 32,
  parameter int ADDR_BITWIDTH = 32
);
  logic                     ce_i;
  logic                     we_i;
  logic [ADDR_BITWIDTH-1:0] addr_i;
  logic [WORD_BITWIDTH-1:0] data_i;
  logic [WORD_BITWIDTH-1:0] data_o;
  logic                     ready_o;
  logic                     err_o;

  modport master (
    output ce_i, we_i, addr_i, data_i,
    input  data_o, ready_o, err_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, data_i,
    output data_o, ready_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering one load/store at a time, one-cycle ready pulse.
// Optional macro DMEM_MISALIGN_CHECK_EN turns non-word-aligned addresses into errors.
//
// state  | meaning
// S_IDLE | waiting for ce_i; accepts and captures the request
// S_WAIT | load in flight; cnt_q counts down to terminal count 1
// S_RESP | ready_o high for this single cycle; returns to S_IDLE
module dmem_responder #(
  parameter int WORD_BITWIDTH = 32,
  parameter int ADDR_BITWIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LAT      = 2
) (
  input logic    clk,
  input logic    rst,
  dmem_if.slave  bus
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     err_q, err_d;
  logic [WORD_BITWIDTH-1:0] data_q, data_d;

  logic [WORD_BITWIDTH-1:0] mem [DEPTH];

  logic             range_err;
  logic             misalign;
  logic             acc_err;
  logic             mem_we;
  logic [IDX_W-1:0] idx_in;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic             ld_err;

  // Upper address bits take part in the range check so addresses never alias.
  assign idx_in    = bus.addr_i[IDX_W+1:2];
  assign range_err = |bus.addr_i[ADDR_BITWIDTH-1:IDX_W+2];
  assign misalign  = |bus.addr_i[1:0];
  assign acc_err   = range_err | (misalign & MISALIGN_EN);
  assign mem_we    = (state_q == S_IDLE) && bus.ce_i && bus.we_i && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    data_d  = data_q;
    rd_idx  = idx_q;
    ld_err  = err_q;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ce_i) begin
          idx_d = idx_in;
          err_d = acc_err;
          if (bus.we_i || (READ_LAT == 1)) begin
            state_d = S_RESP;
            rd_en   = !bus.we_i;
            rd_idx  = idx_in;
            ld_err  = acc_err;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          rd_en   = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Load data is sampled on the edge entering S_RESP; stores leave data_q alone.
    if (rd_en) begin
      data_d = ld_err ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // RAM has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_in] <= bus.data_i;
    end
  end

  assign bus.ready_o = (state_q == S_RESP);
  assign bus.err_o   = (state_q == S_RESP) && err_q;
  assign bus.data_o  = data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (READ_LAT 2, 1, 15) share one
// stimulus path; a negedge monitor pops expected responses and checks data/err/timing.
module tb_dmem_responder;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wdata;
  int          sel;
  logic        rdy, derr;
  logic [31:0] dout;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          rdy_cnt = 0;
  bit          pend = 1'b0;
  exp_t        sb[$];

  dmem_if b0 ();
  dmem_if b1 ();
  dmem_if b2 ();

  dmem_responder #(.READ_LAT(2))  u_lat2  (.clk(clk), .rst(rst), .bus(b0.slave));
  dmem_responder #(.READ_LAT(1))  u_lat1  (.clk(clk), .rst(rst), .bus(b1.slave));
  dmem_responder #(.READ_LAT(15)) u_lat15 (.clk(clk), .rst(rst), .bus(b2.slave));

  assign b0.ce_i = ce && (sel == 0);
  assign b1.ce_i = ce && (sel == 1);
  assign b2.ce_i = ce && (sel == 2);
  assign b0.we_i = we;    assign b1.we_i = we;    assign b2.we_i = we;
  assign b0.addr_i = addr; assign b1.addr_i = addr; assign b2.addr_i = addr;
  assign b0.data_i = wdata; assign b1.data_i = wdata; assign b2.data_i = wdata;

  assign rdy  = (sel == 0) ? b0.ready_o : (sel == 1) ? b1.ready_o : b2.ready_o;
  assign derr = (sel == 0) ? b0.err_o   : (sel == 1) ? b1.err_o   : b2.err_o;
  assign dout = (sel == 0) ? b0.data_o  : (sel == 1) ? b1.data_o  : b2.data_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && rdy) begin
      rdy_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_ready: ready_o=1 at cycle %0d with no request outstanding", cyc);
      end else begin
        e = sb.pop_front();
        check({e.nm, "_data"}, dout, e.d);
        check({e.nm, "_err"}, {31'd0, derr}, {31'd0, e.e});
        check({e.nm, "_cycle"}, cyc, e.c);
      end
    end
  end

  // Called at a negedge; returns at a negedge with ce low (or held high for back-to-back).
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ee, input int lat,
                     input bit hold, input string nm);
    exp_t e;
    int   n;
    int   first;
    first = pend ? 2 : 1;
    e.d   = ed;
    e.e   = ee;
    e.nm  = nm;
    e.c   = cyc + first + lat - 1;
    sb.push_back(e);
    ce = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rdy && n >= first) begin
        addr  = 32'h0000_0010;
        wdata = 32'h5A5A_5A5A;
      end
    end while (!rdy && n < 40);
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: ready_o=0 after %0d cycles, required a pulse", nm, n);
    end
    pend = hold;
    if (!hold) begin
      ce = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] l13, l10;
    int          n0;
    ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 0; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, rdy}, 32'd0);
    check("reset_err", {31'd0, derr}, 32'd0);
    check("reset_data", dout, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    l13 = MIS ? 32'h0 : 32'hDEADBEEF;
    l10 = MIS ? 32'hDEADBEEF : 32'h0000_0077;

    req(1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 0, "st_10");
    req(0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, "ld_10");
    req(1, 32'h1000, 32'h1, 32'hDEADBEEF, 1, 1, 0, "st_oor");
    req(1, 32'h0, 32'h12345678, 32'hDEADBEEF, 0, 1, 0, "st_0");
    req(0, 32'h0, 32'h0, 32'h12345678, 0, 2, 0, "ld_0");
    req(0, 32'h1000, 32'h0, 32'h0, 1, 2, 0, "ld_oor");
    req(0, 32'h8000_0010, 32'h0, 32'h0, 1, 2, 0, "ld_hi");
    req(1, 32'hFFC, 32'hF00DF00D, 32'h0, 0, 1, 0, "st_top");
    req(0, 32'hFFC, 32'h0, 32'hF00DF00D, 0, 2, 0, "ld_top");
    req(0, 32'h13, 32'h0, l13, MIS, 2, 0, "ld_mis");
    req(1, 32'h11, 32'h77, l13, MIS, 1, 0, "st_mis");
    req(0, 32'h10, 32'h0, l10, 0, 2, 0, "ld_after_mis");

    req(1, 32'h4, 32'hCAFEF00D, l10, 0, 1, 1, "b2b_st4");
    req(0, 32'h4, 32'h0, 32'hCAFEF00D, 0, 2, 1, "b2b_ld4");
    req(1, 32'h8, 32'h11, 32'hCAFEF00D, 0, 1, 1, "b2b_st8");
    req(0, 32'h8, 32'h0, 32'h11, 0, 2, 0, "b2b_ld8");

    sel = 1;
    req(1, 32'h4, 32'hABCD0123, 32'h0, 0, 1, 0, "l1_st4");
    req(0, 32'h4, 32'h0, 32'hABCD0123, 0, 1, 0, "l1_ld4");
    req(0, 32'h1000, 32'h0, 32'h0, 1, 1, 0, "l1_ld_oor");

    sel = 2;
    req(1, 32'h4, 32'h600D, 32'h0, 0, 1, 0, "l15_st4");
    req(0, 32'h4, 32'h0, 32'h600D, 0, 15, 0, "l15_ld4");

    // Abort a load part-way through its wait.
    ce = 1'b1; we = 1'b0; addr = 32'h4;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midwait_rst_ready", {31'd0, rdy}, 32'd0);
    check("midwait_rst_err", {31'd0, derr}, 32'd0);
    check("midwait_rst_data", dout, 32'd0);
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pend = 1'b0;
    n0 = rdy_cnt;
    repeat (25) @(negedge clk);
    check("no_stray_after_rst", rdy_cnt, n0);

    req(0, 32'h4, 32'h0, 32'h600D, 0, 15, 0, "l15_ld4_post_rst");
    sel = 0;
    req(0, 32'h0, 32'h0, 32'h12345678, 0, 2, 0, "ld_0_post_rst");

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
